// File: rtl/hydra_mem_pkg.sv
// Shared types and constants for the hydra memory arbiter.
package hydra_mem_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_t;

    localparam int unsigned REGION_RAM  = 0;
    localparam int unsigned REGION_LED  = 1;
    localparam int unsigned REGION_UART = 2;

    localparam int unsigned ERR_RDATA = 0;

endpackage

// File: rtl/hydra_rr_pick.sv
// Combinational winner select: round-robin from last_grant+1, or fixed priority (port 0 first).
module hydra_rr_pick #(
    parameter int unsigned N_PORTS = 4
) (
    input  logic [N_PORTS-1:0]         i_req,
    input  logic [$clog2(N_PORTS)-1:0] i_last,
    input  logic                       i_prio_mode,
    output logic                       o_valid,
    output logic [$clog2(N_PORTS)-1:0] o_idx
);

    localparam int unsigned IDX_W = $clog2(N_PORTS);

    int unsigned w_p;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        w_p     = 0;
        if (i_prio_mode) begin
            for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
                if (i_req[i]) o_idx = IDX_W'(i);
            end
        end else begin
            for (int unsigned k = N_PORTS; k >= 1; k--) begin
                w_p = (32'(i_last) + k) % N_PORTS;
                if (i_req[w_p]) o_idx = IDX_W'(w_p);
            end
        end
    end

endmodule

// File: rtl/hydra_mem_arbiter.sv
// N-port memory arbiter with region decode, slave valid/ready and per-port error responses.
// Optional slave-wait timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module hydra_mem_arbiter
    import hydra_mem_pkg::*;
#(
    parameter int unsigned N_PORTS        = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned N_REGIONS      = 3,
    parameter int unsigned SEL_HI         = 31,
    parameter int unsigned SEL_LO         = 28,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_prio_mode,
    input  logic [N_PORTS-1:0]            i_req_valid,
    input  logic [N_PORTS-1:0]            i_req_we,
    input  logic [N_PORTS*ADDR_W-1:0]     i_req_addr,
    input  logic [N_PORTS*DATA_W-1:0]     i_req_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0]   i_req_wstrb,
    output logic [N_PORTS-1:0]            o_rsp_ready,
    output logic [N_PORTS*DATA_W-1:0]     o_rsp_rdata,
    output logic [N_PORTS-1:0]            o_rsp_err,
    output logic                          o_s_valid,
    output logic                          o_s_we,
    output logic [ADDR_W-1:0]             o_s_addr,
    output logic [DATA_W-1:0]             o_s_wdata,
    output logic [DATA_W/8-1:0]           o_s_wstrb,
    output logic [N_REGIONS-1:0]          o_s_sel,
    input  logic                          i_s_ready,
    input  logic [DATA_W-1:0]             i_s_rdata,
    output logic [$clog2(N_PORTS)-1:0]    o_grant_id
);

    localparam int unsigned IDX_W  = $clog2(N_PORTS);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned REG_W  = SEL_HI - SEL_LO + 1;

    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [ADDR_W-1:0]    w_addr;
    logic [REG_W-1:0]     w_region;
    logic                 w_mapped;
    logic [N_REGIONS-1:0] w_sel;

    state_t                r_state;
    logic [IDX_W-1:0]      r_last;
    logic [IDX_W-1:0]      r_win;
    logic                  r_rsp_due;
    logic                  r_s_valid;
    logic                  r_s_we;
    logic [ADDR_W-1:0]     r_s_addr;
    logic [DATA_W-1:0]     r_s_wdata;
    logic [STRB_W-1:0]     r_s_wstrb;
    logic [N_REGIONS-1:0]  r_s_sel;
    logic [N_PORTS-1:0]    r_rsp_ready;
    logic [N_PORTS-1:0]    r_rsp_err;
    logic [N_PORTS*DATA_W-1:0] r_rsp_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
`endif

    hydra_rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .i_req       (i_req_valid),
        .i_last      (r_last),
        .i_prio_mode (i_prio_mode),
        .o_valid     (w_pick_valid),
        .o_idx       (w_pick_idx)
    );

    assign w_addr   = i_req_addr[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_region = w_addr[SEL_HI:SEL_LO];
    assign w_mapped = 32'(w_region) < N_REGIONS;
    assign w_sel    = N_REGIONS'(1) << w_region;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_last      <= IDX_W'(N_PORTS - 1);
            r_win       <= '0;
            r_rsp_due   <= 1'b0;
            r_s_valid   <= 1'b0;
            r_s_we      <= 1'b0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_s_sel     <= '0;
            r_rsp_ready <= '0;
            r_rsp_err   <= '0;
            r_rsp_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            r_tmo       <= '0;
`endif
        end else begin
            r_rsp_ready <= '0;
            r_rsp_err   <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_pick_valid) begin
                        r_win  <= w_pick_idx;
                        r_last <= w_pick_idx;
                        if (w_mapped) begin
                            r_state   <= StIssue;
                            r_s_valid <= 1'b1;
                            r_s_we    <= i_req_we[w_pick_idx];
                            r_s_addr  <= w_addr;
                            r_s_wdata <= i_req_wdata[w_pick_idx*DATA_W +: DATA_W];
                            r_s_wstrb <= i_req_wstrb[w_pick_idx*STRB_W +: STRB_W];
                            r_s_sel   <= w_sel;
`ifdef MEM_ARB_TIMEOUT_EN
                            r_tmo     <= '0;
`endif
                        end else begin
                            // Unmapped: spend one RESP cycle so the pulse lands at t+2.
                            r_state   <= StResp;
                            r_rsp_due <= 1'b1;
                        end
                    end
                end
                StIssue: begin
                    if (i_s_ready) begin
                        r_state            <= StResp;
                        r_s_valid          <= 1'b0;
                        r_s_sel            <= '0;
                        r_rsp_ready[r_win] <= 1'b1;
                        if (!r_s_we) r_rsp_rdata[r_win*DATA_W +: DATA_W] <= i_s_rdata;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_state            <= StResp;
                        r_s_valid          <= 1'b0;
                        r_s_sel            <= '0;
                        r_rsp_ready[r_win] <= 1'b1;
                        r_rsp_err[r_win]   <= 1'b1;
                        r_rsp_rdata[r_win*DATA_W +: DATA_W] <= DATA_W'(ERR_RDATA);
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
`endif
                end
                StResp: begin
                    if (r_rsp_due) begin
                        r_rsp_due          <= 1'b0;
                        r_rsp_ready[r_win] <= 1'b1;
                        r_rsp_err[r_win]   <= 1'b1;
                        r_rsp_rdata[r_win*DATA_W +: DATA_W] <= DATA_W'(ERR_RDATA);
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_rsp_ready = r_rsp_ready;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_s_valid   = r_s_valid;
    assign o_s_we      = r_s_we;
    assign o_s_addr    = r_s_addr;
    assign o_s_wdata   = r_s_wdata;
    assign o_s_wstrb   = r_s_wstrb;
    assign o_s_sel     = r_s_sel;
    assign o_grant_id  = r_win;

endmodule
